// File: rtl/shift_right_seq_if.sv
// Request/response bundle for the multi-cycle right shifter.
// The shifter is the slave; the requesting datapath is the master.
interface shift_right_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
);
  logic             start_i;
  logic             arith_i;
  logic [WIDTH-1:0] data_i;
  logic [SHW-1:0]   shamt_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] data_o;

  modport slave (
    input  start_i,
    input  arith_i,
    input  data_i,
    input  shamt_i,
    output busy_o,
    output done_o,
    output data_o
  );

  modport master (
    output start_i,
    output arith_i,
    output data_i,
    output shamt_i,
    input  busy_o,
    input  done_o,
    input  data_o
  );
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle logical/arithmetic right shifter, STEP bits per cycle, start/done handshake.
// A new request is accepted in IDLE or DONE, so back-to-back operations run with no bubble.
module shift_right_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  shift_right_seq_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam logic [SHW-1:0] StepAmt = SHW'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             accept;
  logic [SHW-1:0]   step_k;
  logic [SHW-1:0]   cnt_rem;
  logic [WIDTH-1:0] fill_mask;
  logic [WIDTH-1:0] shifted;

  // Requests arriving mid-shift are dropped, never queued.
  assign accept = bus.start_i && (state_q != StShift);

  // Final step may be shorter than STEP when shamt is not a multiple of it.
  assign step_k    = (cnt_q < StepAmt) ? cnt_q : StepAmt;
  assign cnt_rem   = cnt_q - step_k;
  assign fill_mask = fill_q ? ~({WIDTH{1'b1}} >> step_k) : '0;
  assign shifted   = (acc_q >> step_k) | fill_mask;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    data_d  = data_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          acc_d  = bus.data_i;
          cnt_d  = bus.shamt_i;
          // Sign is frozen at acceptance so later data_i changes cannot alter the fill.
          fill_d = bus.arith_i & bus.data_i[WIDTH-1];
          if (bus.shamt_i != '0) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
            data_d  = bus.data_i;
          end
        end
      end
      StShift: begin
        acc_d = shifted;
        cnt_d = cnt_rem;
        if (cnt_rem == '0) begin
          state_d = StDone;
          data_d  = shifted;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
    end
  end

  // Status is decoded from the state register only; no input reaches an output combinationally.
  assign bus.busy_o = (state_q == StShift);
  assign bus.done_o = (state_q == StDone);
  assign bus.data_o = data_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: a STEP=1 and a STEP=4 instance side by side.
module tb_shift_right_seq;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_right_seq_if #(.WIDTH(32), .SHW(5)) b1 ();
  shift_right_seq_if #(.WIDTH(32), .SHW(5)) b4 ();

  shift_right_seq #(.WIDTH(32), .SHW(5), .STEP(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b1)
  );

  shift_right_seq #(.WIDTH(32), .SHW(5), .STEP(4)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (b4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one request; the expectation comes from the shift operators, not from stepping.
  task automatic issue(input bit s4, input logic [31:0] d, input int sh, input bit ar);
    exp_t e;
    int   step;
    step = s4 ? 4 : 1;
    if (ar) e.res = $signed(d) >>> sh;
    else    e.res = d >> sh;
    @(negedge clk);
    if (s4) begin
      b4.start_i = 1'b1; b4.data_i = d; b4.shamt_i = 5'(sh); b4.arith_i = ar;
    end else begin
      b1.start_i = 1'b1; b1.data_i = d; b1.shamt_i = 5'(sh); b1.arith_i = ar;
    end
    @(posedge clk);
    #1;
    e.cyc = cyc + (sh + step - 1) / step;
    if (s4) begin q4.push_back(e); b4.start_i = 1'b0; end
    else    begin q1.push_back(e); b1.start_i = 1'b0; end
  endtask

  // One-cycle start with unrelated operands while the instance is shifting.
  task automatic junk_pulse(input bit s4);
    @(negedge clk);
    if (s4) begin
      b4.start_i = 1'b1; b4.data_i = $urandom; b4.shamt_i = 5'($urandom); b4.arith_i = 1'($urandom);
    end else begin
      b1.start_i = 1'b1; b1.data_i = $urandom; b1.shamt_i = 5'($urandom); b1.arith_i = 1'($urandom);
    end
    @(posedge clk);
    #1;
    if (s4) b4.start_i = 1'b0;
    else    b1.start_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(q1.size() + q4.size()), 32'd0);
    q1.delete();
    q4.delete();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (b1.done_o) begin
        if (q1.size() == 0) check_eq("s1_unexpected_done", 32'(b1.done_o), 32'd0);
        else begin
          e = q1.pop_front();
          check_eq("s1_data", b1.data_o, e.res);
          check_eq("s1_latency", 32'(cyc), 32'(e.cyc));
        end
      end
      if (b4.done_o) begin
        if (q4.size() == 0) check_eq("s4_unexpected_done", 32'(b4.done_o), 32'd0);
        else begin
          e = q4.pop_front();
          check_eq("s4_data", b4.data_o, e.res);
          check_eq("s4_latency", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    b1.start_i = 1'b0; b1.arith_i = 1'b0; b1.data_i = '0; b1.shamt_i = '0;
    b4.start_i = 1'b0; b4.arith_i = 1'b0; b4.data_i = '0; b4.shamt_i = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy1", 32'(b1.busy_o), 32'd0);
    check_eq("reset_done1", 32'(b1.done_o), 32'd0);
    check_eq("reset_data1", b1.data_o, 32'd0);
    check_eq("reset_busy4", 32'(b4.busy_o), 32'd0);
    check_eq("reset_data4", b4.data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Logical and arithmetic directed cases, STEP=1.
    issue(0, 32'h8000_0000, 31, 0); drain();
    issue(0, 32'h0000_1000, 2, 0);  drain();
    issue(0, 32'hF000_0000, 4, 1);  drain();
    issue(0, 32'hF000_0000, 4, 0);  drain();
    issue(0, 32'h7000_0000, 4, 1);  drain();

    // Zero shift followed by a request held through the DONE cycle.
    issue(0, 32'h1234_5678, 0, 0);
    issue(0, 32'h0000_0100, 8, 0);
    drain();
    issue(1, 32'h1234_5678, 0, 0);
    issue(1, 32'h0000_0100, 8, 0);
    drain();

    // STEP=4 with a partial last step, and requests ignored while shifting.
    issue(1, 32'h8000_0000, 7, 1);
    junk_pulse(1);
    drain();
    issue(0, 32'hA5A5_A5A5, 20, 1);
    repeat (3) junk_pulse(0);
    drain();
    issue(1, 32'hC000_0003, 31, 1);
    junk_pulse(1);
    drain();

    for (int i = 0; i < 16; i++) begin
      issue(i[0], $urandom, int'($urandom_range(0, 31)), 1'($urandom));
      drain();
    end

    // Asynchronous reset in the middle of a shift; the aborted operation must not complete.
    issue(0, 32'hDEAD_BEEF, 4, 0); drain();
    issue(0, 32'hFFFF_0000, 16, 0);
    repeat (3) @(negedge clk);
    check_eq("pre_reset_busy", 32'(b1.busy_o), 32'd1);
    check_eq("pre_reset_data", b1.data_o, 32'h0DEA_DBEE);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", 32'(b1.busy_o), 32'd0);
    check_eq("async_rst_done", 32'(b1.done_o), 32'd0);
    check_eq("async_rst_data", b1.data_o, 32'd0);
    q1.delete();
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check_eq("post_rst_busy", 32'(b1.busy_o), 32'd0);
    check_eq("post_rst_data", b1.data_o, 32'd0);

    // Normal operation resumes after the reset.
    issue(0, 32'h0000_1000, 2, 0); drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right shifter for the ALU shift path. Executes MIPS srl/srlv (logical) and sra/srav (arithmetic).
- It is the inverse-direction companion of the fixed left-by-two offset shifter. It also serves byte-address to word-index conversion (shamt=2, logical).
- Iterates STEP bits per cycle with a start/done handshake, so the main datapath holds off while it runs.

Parameters:
- WIDTH, 32, data width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).
- STEP, 1, bits shifted per cycle; legal values 1, 2, 4, 8.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled on the rising edge of clk_i.
- arith_i  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled with start_i.
- data_i  input  WIDTH  operand; sampled with start_i.
- shamt_i  input  SHW  shift amount 0..WIDTH-1; sampled with start_i.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse; result valid on data_o.
- data_o  output  WIDTH  result register.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE; busy_o=0, done_o=0, data_o=0; internal accumulator, count and mode cleared.
  - Takes effect immediately, including mid-operation. The aborted operation produces no done_o.
- States: IDLE, SHIFT, DONE.
- Acceptance: start_i is accepted on a rising edge when state is IDLE or DONE. On acceptance:
  - acc<=data_i, cnt<=shamt_i, fill<=arith_i & data_i[WIDTH-1].
  - Next state is SHIFT if shamt_i!=0, else DONE with data_o<=data_i.
- start_i while in SHIFT is ignored. Inputs are not captured and there is no queueing.
- SHIFT, each edge:
  - k=min(STEP,cnt). acc<=acc>>k, with the top k bits set to fill. cnt<=cnt-k.
  - When cnt-k==0: data_o<=shifted value and next state DONE.
- DONE: lasts exactly one cycle.
  - Next state is IDLE, or is governed by acceptance if start_i=1 (back-to-back allowed, zero bubble).
- Output decoding:
  - busy_o=1 iff state==SHIFT.
  - done_o=1 iff state==DONE.
  - Both are decoded from the state register only, with no combinational input-to-output path.
- Latency: done_o is high in cycle N+1+ceil(shamt/STEP), where N is the cycle whose closing edge accepts start_i.
  - shamt=0 gives 1 cycle.
  - shamt=31, STEP=1 gives 32 cycles.
- data_o holds its last result until the next transition into DONE. It is unchanged during SHIFT and IDLE.
- Arithmetic rule: the sign bit is taken from data_i at acceptance; fill is constant for the whole operation. Logical mode always fills 0.
- shamt_i uses only SHW bits; no value wraps or exceeds WIDTH-1.
- Changes to data_i/arith_i/shamt_i after acceptance have no effect on the running operation.

Test Plan:
- Reset mid-run: start with data_i=0xFFFF0000, shamt=16. Drop rst_i in cycle 5 → busy_o, done_o and data_o all 0 asynchronously. After release, state is IDLE and no done_o appears.
- Logical shifts, STEP=1:
  - data_i=0x80000000, shamt=31, arith=0 → done_o in cycle 32, data_o=0x00000001.
  - data_i=0x00001000, shamt=2 → done_o in cycle 3, data_o=0x00000400.
- Arithmetic shift: data_i=0xF0000000, shamt=4, arith=1 → data_o=0xFF000000.
  - Same with arith=0 → data_o=0x0F000000.
  - data_i=0x70000000, arith=1, shamt=4 → data_o=0x07000000.
- Zero shift and back-to-back:
  - shamt=0, data_i=0x12345678 → done_o one cycle after start, data_o=0x12345678.
  - Hold start_i high in the DONE cycle with data_i=0x00000100, shamt=8 → second done_o 9 cycles later, data_o=0x00000001.
- Ignored start and STEP=4:
  - With STEP=4, data_i=0x80000000, shamt=7, arith=1 → done_o after 1+2 cycles, data_o=0xFF000000.
  - Pulsing start_i with different data during SHIFT does not change the result or the latency.
